// File: rtl/phase_tap_tracker_if.sv
`timescale 1ns/1ps
// Sample, enable and button inputs of the phi0 tap tracker together with its tap and status outputs.
interface phase_tap_tracker_if #(
  parameter int TAP_W  = 8,
  parameter int DIFF_W = 16
);
  logic                     enable;
  logic signed [DIFF_W-1:0] diff;
  logic                     diff_valid;
  logic                     man_inc;
  logic                     man_dec;
  logic [TAP_W-1:0]         tap;
  logic                     locked;
  logic                     tap_changed;
  logic                     at_limit;

  modport master (
    output enable, diff, diff_valid, man_inc, man_dec,
    input  tap, locked, tap_changed, at_limit
  );

  modport slave (
    input  enable, diff, diff_valid, man_inc, man_dec,
    output tap, locked, tap_changed, at_limit
  );
endinterface

// File: rtl/phase_tap_tracker.sv
`timescale 1ns/1ps
// Closed-loop phi0 tap controller: averages phase-difference samples and steps the delay-line tap.
// New tap lands 2 cycles after the last averaged sample (1 cycle after a button); no backpressure.
module phase_tap_tracker #(
  parameter int TAP_W          = 8,
  parameter int TAP_INITIAL    = 19,
  parameter int TAP_MIN        = 0,
  parameter int TAP_MAX        = 255,
  parameter int DIFF_W         = 16,
  parameter int TARGET         = 0,
  parameter int DEADBAND       = 1,
  parameter int COARSE         = 8,
  parameter int COARSE_STEP    = 4,
  parameter int AVG_LOG2       = 2,
  parameter int SETTLE_SAMPLES = 2,
  parameter int LOCK_COUNT     = 4
) (
  input logic                eclk,
  input logic                ereset_n,
  phase_tap_tracker_if.slave io
);
  localparam int ACC_W = DIFF_W + AVG_LOG2;
  localparam int ERR_W = DIFF_W + 1;
  localparam int TW    = TAP_W + 2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int NSAMP = 1 << AVG_LOG2;
  localparam int SET_W = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
  localparam int LCK_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, EVAL, SETTLE} state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt;
  logic [SET_W-1:0]         set_cnt;
  logic [LCK_W-1:0]         lock_cnt;
  logic [TAP_W-1:0]         tap_q;
  logic                     locked_q;
  logic                     changed_q;
  logic                     limit_q;

  logic signed [ERR_W-1:0]  err;
  logic signed [ERR_W-1:0]  err_abs;
  logic                     in_band;
  logic signed [TW-1:0]     step;
  logic signed [TW-1:0]     tap_s;
  logic [TAP_W-1:0]         auto_val;
  logic                     auto_lim;
  logic [TAP_W-1:0]         man_val;
  logic                     man_lim;
  logic                     man_req;
  logic                     man_chg;
  logic [LCK_W-1:0]         lock_nxt;

  // Tap arithmetic runs two bits wider and signed so clamping never sees a wrapped value.
  function automatic void clamp_tap(input logic signed [TW-1:0] v,
                                    output logic [TAP_W-1:0] val, output logic lim);
    if (v > TW'(TAP_MAX)) begin
      val = TAP_W'(TAP_MAX);
      lim = 1'b1;
    end else if (v < TW'(TAP_MIN)) begin
      val = TAP_W'(TAP_MIN);
      lim = 1'b1;
    end else begin
      val = v[TAP_W-1:0];
      lim = 1'b0;
    end
  endfunction

  always_comb begin
    err      = ERR_W'(acc >>> AVG_LOG2) - ERR_W'(TARGET);
    err_abs  = err[ERR_W-1] ? -err : err;
    in_band  = (err_abs <= ERR_W'(DEADBAND));
    step     = (err_abs > ERR_W'(COARSE)) ? TW'(COARSE_STEP) : TW'(1);
    tap_s    = $signed({2'b00, tap_q});
    clamp_tap(err[ERR_W-1] ? tap_s + step : tap_s - step, auto_val, auto_lim);
    clamp_tap(io.man_inc ? tap_s + TW'(1) : tap_s - TW'(1), man_val, man_lim);
    man_req  = io.man_inc ^ io.man_dec;
    man_chg  = man_req && (man_val != tap_q);
    lock_nxt = (lock_cnt == LCK_W'(LOCK_COUNT)) ? lock_cnt : lock_cnt + 1'b1;
  end

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      set_cnt   <= '0;
      lock_cnt  <= '0;
      tap_q     <= TAP_W'(TAP_INITIAL);
      locked_q  <= 1'b0;
      changed_q <= 1'b0;
      limit_q   <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      if (man_chg) begin
        tap_q     <= man_val;
        limit_q   <= man_lim;
        changed_q <= 1'b1;
        locked_q  <= 1'b0;
        lock_cnt  <= '0;
        acc       <= '0;
        cnt       <= '0;
        set_cnt   <= '0;
        state     <= io.enable ? SETTLE : IDLE;
      end else begin
        if (man_req) limit_q <= man_lim;
        unique case (state)
          IDLE: begin
            acc <= '0;
            cnt <= '0;
            if (io.enable) state <= ACCUM;
          end
          ACCUM: begin
            if (!io.enable) begin
              acc      <= '0;
              cnt      <= '0;
              locked_q <= 1'b0;
              lock_cnt <= '0;
              state    <= IDLE;
            end else if (io.diff_valid) begin
              acc <= acc + ACC_W'(io.diff);
              cnt <= cnt + 1'b1;
              if (cnt == CNT_W'(NSAMP - 1)) state <= EVAL;
            end
          end
          EVAL: begin
            acc     <= '0;
            cnt     <= '0;
            set_cnt <= '0;
            state   <= ACCUM;
            // A no-op button press in this cycle still pre-empts the automatic step.
            if (!man_req) begin
              if (in_band) begin
                lock_cnt <= lock_nxt;
                locked_q <= (lock_nxt == LCK_W'(LOCK_COUNT));
              end else begin
                lock_cnt <= '0;
                locked_q <= 1'b0;
                limit_q  <= auto_lim;
                if (auto_val != tap_q) begin
                  tap_q     <= auto_val;
                  changed_q <= 1'b1;
                  state     <= SETTLE;
                end
              end
            end
          end
          SETTLE: begin
            if (!io.enable) begin
              locked_q <= 1'b0;
              lock_cnt <= '0;
              state    <= IDLE;
            end else if (SETTLE_SAMPLES == 0) begin
              state <= ACCUM;
            end else if (io.diff_valid) begin
              set_cnt <= set_cnt + 1'b1;
              if (set_cnt == SET_W'(SETTLE_SAMPLES - 1)) state <= ACCUM;
            end
          end
        endcase
      end
    end
  end

  assign io.tap         = tap_q;
  assign io.locked      = locked_q;
  assign io.tap_changed = changed_q;
  assign io.at_limit    = limit_q;
endmodule

// File: doc/phase_tap_tracker.md
Name: phase_tap_tracker

Overview:
- Closed-loop controller that consumes the signed phi0/phi2 phase difference measured in emulation-clock ticks.
- Drives the phi0 delay-line tap index that feeds the 6502 model's clock input, replacing open-loop button-only tap adjustment.
- Averages difference samples, steps the tap towards a target phase, and reports lock.
- Manual increment/decrement requests from the debounced buttons remain available and override the loop.

Parameters:
- TAP_W, 8, width of the tap index.
- TAP_INITIAL, 19, tap value after reset.
- TAP_MIN, 0, lowest legal tap.
- TAP_MAX, 255, highest legal tap.
- DIFF_W, 16, width of the signed difference input.
- TARGET, 0, desired signed difference in ticks.
- DEADBAND, 1, maximum |error| counted as in-band.
- COARSE, 8, |error| above which the step is COARSE_STEP instead of 1.
- COARSE_STEP, 4, large step size.
- AVG_LOG2, 2, number of samples averaged per evaluation is 2^AVG_LOG2.
- SETTLE_SAMPLES, 2, valid samples discarded after any tap change.
- LOCK_COUNT, 4, consecutive in-band evaluations needed to assert locked.

Ports:
- eclk  input  1  emulation clock, all logic on rising edge.
- ereset_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = automatic tracking, 0 = hold and manual only.
- diff  input  DIFF_W  signed phase difference, two's complement.
- diff_valid  input  1  one-cycle strobe; diff is a new sample.
- man_inc  input  1  one-cycle manual tap+1 request.
- man_dec  input  1  one-cycle manual tap-1 request.
- tap  output  TAP_W  current delay-line tap.
- locked  output  1  loop in band.
- tap_changed  output  1  one-cycle pulse, tap updated this cycle.
- at_limit  output  1  last requested step was clamped at TAP_MIN or TAP_MAX.

Behaviour:
- Reset (async assert, sync release):
  - tap = TAP_INITIAL.
  - locked, tap_changed, at_limit = 0.
  - State IDLE; accumulator, sample count, settle count and lock count all 0.
- Accumulator:
  - Signed, DIFF_W+AVG_LOG2 bits, sign-extended adds; cannot overflow.
  - avg = acc arithmetic-shifted right by AVG_LOG2.
  - err = avg - TARGET, computed at DIFF_W+1 bits.
- State IDLE:
  - If enable=1, go to ACCUM next cycle; otherwise stay.
  - Accumulator held at 0.
- State ACCUM:
  - Each diff_valid adds diff and increments the sample count.
  - When count reaches 2^AVG_LOG2, go to EVAL.
  - If enable drops, clear accumulator and count, clear locked, go to IDLE.
- State EVAL (one cycle):
  - |err| <= DEADBAND: increment lock count, saturating at LOCK_COUNT; locked=1 when count = LOCK_COUNT; tap unchanged; return to ACCUM with accumulator cleared.
  - Otherwise: clear lock count and locked.
  - step = COARSE_STEP if |err| > COARSE, else 1.
  - err > 0 decrements tap by step; err < 0 increments tap by step.
  - Result clamped to [TAP_MIN, TAP_MAX]. at_limit=1 if clamped, else 0.
  - tap_changed=1 if the tap value actually differs; go to SETTLE.
  - If the clamped result equals the current tap, return to ACCUM instead.
- State SETTLE:
  - Discard SETTLE_SAMPLES diff_valid strobes, then go to ACCUM with accumulator cleared.
- tap update timing:
  - tap updates on the eclk edge ending EVAL.
  - tap_changed is high the following cycle only.
  - Latency from the final averaged sample's diff_valid to the new tap is 2 cycles.
- Manual requests:
  - Honoured in every state, including when enable=0.
  - Take priority over an EVAL step in the same cycle.
  - man_inc: tap+1, clamped. man_dec: tap-1, clamped. at_limit set as for auto steps.
  - Both asserted together: ignored, no change.
  - A manual change clears locked and lock count, clears the accumulator, and enters SETTLE (IDLE if enable=0).
- diff_valid during IDLE is ignored.
- A diff_valid in the same cycle as EVAL is discarded.
- No wrap-around of tap under any condition.

Test Plan:
- Reset with enable=0, then pulse man_inc three times → tap=22, three tap_changed pulses, locked=0.
- enable=1; feed diff=+3 ×4 → avg 3, err 3 > DEADBAND → tap 19→18; next 2 samples ignored (SETTLE).
- enable=1; feed diff=-20 ×4 → |err| 20 > COARSE → tap 19→23, tap_changed pulse 2 cycles after the 4th diff_valid.
- Feed diff ∈ {1,0,-1,0} repeatedly → locked rises after the 4th consecutive in-band evaluation (16 samples); tap stays 19. Then man_dec → locked=0, tap=18.
- tap=TAP_MAX=255, auto err=-20 → tap stays 255, at_limit=1, no tap_changed. Also tap=0 with man_dec → stays 0, at_limit=1.
- Assert ereset_n low mid-ACCUM after 2 samples → tap=19, locked=0 immediately; after release, 4 fresh samples are required before any step.
